// File: rtl/clb_array_cfg_pkg.sv
// Shared types and configuration-layout helpers for the configurable logic block.
package clb_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } cfg_state_e;

    // Bits needed to encode v distinct values; never less than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Field offsets within one BLE slice, LSB first.
    function automatic int lut_off();
        return 0;
    endfunction

    function automatic int sel_off(input int k, input int lut_k, input int selw);
        return (1 << lut_k) + k * selw;
    endfunction

    function automatic int reg_off(input int lut_k, input int selw);
        return (1 << lut_k) + lut_k * selw;
    endfunction

    function automatic int init_off(input int lut_k, input int selw);
        return reg_off(lut_k, selw) + 1;
    endfunction

    function automatic int sre_off(input int lut_k, input int selw);
        return reg_off(lut_k, selw) + 2;
    endfunction

endpackage

// File: rtl/clb_array_cfg_if.sv
// Data and configuration-chain signals of one logic tile.
interface clb_array_cfg_if #(
    parameter int N_IN  = 4,
    parameter int N_BLE = 2
);
    logic [N_IN-1:0]  I;
    logic             S;
    logic             R;
    logic             CFG_EN;
    logic             CFG_DI;
    logic             CFG_DO;
    logic             CFG_DONE;
    logic [N_BLE-1:0] O;

    modport master (
        output I, S, R, CFG_EN, CFG_DI,
        input  CFG_DO, CFG_DONE, O
    );

    modport slave (
        input  I, S, R, CFG_EN, CFG_DI,
        output CFG_DO, CFG_DONE, O
    );
endinterface

// File: rtl/clb_array_cfg_ble.sv
// One basic logic element: input muxes, LUT, flop with optional sync set/reset,
// and the registered/combinational output select.
module clb_ble
    import clb_pkg::*;
#(
    parameter int LUT_K    = 4,
    parameter int N_IN     = 4,
    parameter int N_BLE    = 2,
    parameter int SELW     = 3,
    parameter int BLE_BITS = (1 << LUT_K) + LUT_K * SELW + 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BLE_BITS-1:0] cfg,
    input  logic [N_IN-1:0]     i_data,
    input  logic [N_BLE-1:0]    q_fb,
    input  logic                s,
    input  logic                r,
    input  logic                run,
    input  logic                load_init,
    output logic                q,
    output logic                o
);
    localparam int LUT_N    = 1 << LUT_K;
    localparam int NSRC     = N_IN + N_BLE;
    localparam int LUT_OFF  = lut_off();
    localparam int REG_OFF  = reg_off(LUT_K, SELW);
    localparam int INIT_OFF = init_off(LUT_K, SELW);
    localparam int SRE_OFF  = sre_off(LUT_K, SELW);

    logic [LUT_N-1:0] lut;
    logic [LUT_K-1:0] lut_in;
    logic [NSRC-1:0]  src;
    logic             f;
    logic             reg_en;
    logic             init_v;
    logic             sre;
    logic             q_q;
    logic             q_d;

    assign lut    = cfg[LUT_OFF +: LUT_N];
    assign reg_en = cfg[REG_OFF];
    assign init_v = cfg[INIT_OFF];
    assign sre    = cfg[SRE_OFF];

    // Feedback comes only from registered Q, so no combinational loop can form
    // through the muxes regardless of configuration.
    assign src = {q_fb, i_data};

    for (genvar k = 0; k < LUT_K; k++) begin : g_in
        logic [SELW-1:0] sel_k;
        assign sel_k     = cfg[sel_off(k, LUT_K, SELW) +: SELW];
        assign lut_in[k] = ({1'b0, sel_k} < (SELW + 1)'(NSRC)) ? src[sel_k] : 1'b0;
    end

    assign f = lut[lut_in];

    // Next flop value: INIT on the completing load edge, else R/S/F while running.
    always_comb begin
        q_d = q_q;
        if (load_init) begin
            q_d = init_v;
        end else if (run) begin
            if (sre && r) begin
                q_d = 1'b0;
            end else if (sre && s) begin
                q_d = 1'b1;
            end else begin
                q_d = f;
            end
        end
    end

    // BLE state flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
    assign o = run ? (reg_en ? q_q : f) : 1'b0;

endmodule

// File: rtl/clb_array_cfg.sv
// Logic tile: N_BLE configurable BLEs behind a serial configuration chain.
//
//  state | meaning
//  UNCFG | after reset, no configuration loaded, outputs forced low
//  LOAD  | shifting configuration (CFG_EN pauses), outputs forced low
//  RUN   | configuration complete, BLEs active, CFG_DONE high
module clb_array_cfg
    import clb_pkg::*;
#(
    parameter int LUT_K = 4,
    parameter int N_IN  = 4,
    parameter int N_BLE = 2
) (
    input  logic          K,
    input  logic          RST_N,
    clb_array_cfg_if.slave bus
);
    localparam int SELW     = clog2(N_IN + N_BLE);
    localparam int BLE_BITS = (1 << LUT_K) + LUT_K * SELW + 3;
    localparam int CFG_BITS = N_BLE * BLE_BITS;
    localparam int CNTW     = clog2(CFG_BITS);

    cfg_state_e          state_q, state_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [CFG_BITS-1:0] cfg_q, cfg_d;
    logic                done_q, done_d;
    logic                load_init;
    logic [N_BLE-1:0]    q_vec;
    logic [N_BLE-1:0]    o_vec;

    // Next-state, bit counter and shift-register update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cfg_d     = cfg_q;
        load_init = 1'b0;
        case (state_q)
            UNCFG: begin
                if (bus.CFG_EN) begin
                    cfg_d   = {bus.CFG_DI, cfg_q[CFG_BITS-1:1]};
                    cnt_d   = CNTW'(1);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (bus.CFG_EN) begin
                    cfg_d = {bus.CFG_DI, cfg_q[CFG_BITS-1:1]};
                    if (cnt_q == CNTW'(CFG_BITS - 1)) begin
                        cnt_d     = '0;
                        state_d   = RUN;
                        load_init = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            RUN: begin
                // Reconfiguration entry edge: no shift, counter restarts.
                if (bus.CFG_EN) begin
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = UNCFG;
            end
        endcase
        done_d = (state_d == RUN);
    end

    // Control state registers; CFG_DONE is a registered decode of RUN.
    always_ff @(posedge K or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= UNCFG;
            cnt_q   <= '0;
            cfg_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
            done_q  <= done_d;
        end
    end

    // BLEs see the post-edge configuration: static (equal to cfg_q) while
    // running, and on the completing shift it carries the freshly loaded INIT.
    for (genvar b = 0; b < N_BLE; b++) begin : g_ble
        clb_ble #(
            .LUT_K   (LUT_K),
            .N_IN    (N_IN),
            .N_BLE   (N_BLE),
            .SELW    (SELW),
            .BLE_BITS(BLE_BITS)
        ) u_ble (
            .clk      (K),
            .rst_n    (RST_N),
            .cfg      (cfg_d[b*BLE_BITS +: BLE_BITS]),
            .i_data   (bus.I),
            .q_fb     (q_vec),
            .s        (bus.S),
            .r        (bus.R),
            .run      (done_q),
            .load_init(load_init),
            .q        (q_vec[b]),
            .o        (o_vec[b])
        );
    end

    assign bus.O        = o_vec;
    assign bus.CFG_DO   = cfg_q[0];
    assign bus.CFG_DONE = done_q;

endmodule

// File: tb/tb_clb_array_cfg.sv
// Directed self-checking bench for clb_array_cfg with default parameters.
module tb_clb_array_cfg;
    localparam int LUT_K    = 4;
    localparam int N_IN     = 4;
    localparam int N_BLE    = 2;
    localparam int CFG_BITS = 62;

    typedef struct {
        logic [3:0] i;
        logic       s;
        logic       r;
        logic       tick;
        logic [1:0] exp_o;
    } vec_t;

    logic K = 1'b0;
    logic RST_N;
    int   errors = 0;
    int   checks = 0;
    vec_t tbl[$];

    logic [CFG_BITS-1:0] c2, c3, c4, c5, c6;

    clb_array_cfg_if #(.N_IN(N_IN), .N_BLE(N_BLE)) bus ();

    clb_array_cfg #(.LUT_K(LUT_K), .N_IN(N_IN), .N_BLE(N_BLE)) dut (
        .K    (K),
        .RST_N(RST_N),
        .bus  (bus)
    );

    always #5 K = ~K;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    function automatic logic [30:0] ble(input logic [15:0] lut,
                                        input logic [2:0] s0, input logic [2:0] s1,
                                        input logic [2:0] s2, input logic [2:0] s3,
                                        input logic rg, input logic init, input logic sre);
        return {sre, init, rg, s3, s2, s1, s0, lut};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge K);
        #1;
    endtask

    task automatic load_cfg(input logic [CFG_BITS-1:0] v, input int pause_after,
                            input logic exp_do_pause);
        for (int n = 0; n < CFG_BITS; n++) begin
            bus.CFG_EN = 1'b1;
            bus.CFG_DI = v[n];
            step();
            if (n == CFG_BITS - 2) chk("done_before_last_bit", 64'(bus.CFG_DONE), 64'd0);
            if (n == pause_after) begin
                bus.CFG_EN = 1'b0;
                bus.CFG_DI = 1'b1;
                for (int p = 0; p < 5; p++) begin
                    step();
                    chk("pause_done", 64'(bus.CFG_DONE), 64'd0);
                    chk("pause_do", 64'(bus.CFG_DO), 64'(exp_do_pause));
                end
            end
        end
        bus.CFG_EN = 1'b0;
        bus.CFG_DI = 1'b0;
        chk("done_after_last_bit", 64'(bus.CFG_DONE), 64'd1);
    endtask

    task automatic abort_run();
        bus.CFG_EN = 1'b1;
        bus.CFG_DI = 1'b1;
        step();
        chk("abort_done", 64'(bus.CFG_DONE), 64'd0);
        chk("abort_o", 64'(bus.O), 64'd0);
    endtask

    task automatic run_tbl(input string nm);
        foreach (tbl[n]) begin
            bus.I = tbl[n].i;
            bus.S = tbl[n].s;
            bus.R = tbl[n].r;
            if (tbl[n].tick) step();
            else #1;
            chk(nm, 64'(bus.O), 64'(tbl[n].exp_o));
        end
        tbl.delete();
        bus.S = 1'b0;
        bus.R = 1'b0;
    endtask

    initial begin
        c2 = {31'b0, ble(16'h0116, 3'd0, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0)};
        c3 = {31'b0, ble(16'h5555, 3'd4, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0)};
        c4 = {ble(16'h0001, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0),
              ble(16'h0000, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1)};
        c5 = {31'b0, ble(16'h0000, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0)};
        c6 = {31'b0, ble(16'hFFFF, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0)};

        RST_N      = 1'b0;
        bus.I      = '0;
        bus.S      = 1'b0;
        bus.R      = 1'b0;
        bus.CFG_EN = 1'b0;
        bus.CFG_DI = 1'b0;
        #2;
        chk("reset_o", 64'(bus.O), 64'd0);
        chk("reset_done", 64'(bus.CFG_DONE), 64'd0);
        chk("reset_do", 64'(bus.CFG_DO), 64'd0);
        #10 RST_N = 1'b1;
        step();
        bus.CFG_EN = 1'b0;
        step();
        chk("uncfg_idle_done", 64'(bus.CFG_DONE), 64'd0);

        // Combinational LUT 0x0116 on I[3:0]
        load_cfg(c2, -1, 1'b0);
        chk("c2_do", 64'(bus.CFG_DO), 64'(c2[0]));
        tbl.push_back('{4'b0100, 1'b0, 1'b0, 1'b0, 2'b01});
        tbl.push_back('{4'b0110, 1'b0, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{4'b0001, 1'b0, 1'b0, 1'b0, 2'b01});
        tbl.push_back('{4'b0010, 1'b0, 1'b0, 1'b0, 2'b01});
        tbl.push_back('{4'b1000, 1'b0, 1'b0, 1'b0, 2'b01});
        tbl.push_back('{4'b1111, 1'b0, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{4'b0100, 1'b0, 1'b0, 1'b0, 2'b01});
        run_tbl("comb_lut");

        // Reconfigure from RUN into the registered feedback toggle
        abort_run();
        bus.I = 4'b0000;
        load_cfg(c3, -1, 1'b0);
        chk("toggle_entry", 64'(bus.O), 64'd1);
        chk("c3_do", 64'(bus.CFG_DO), 64'(c3[0]));
        tbl.push_back('{4'b1111, 1'b0, 1'b0, 1'b1, 2'b00});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 1'b1, 2'b01});
        tbl.push_back('{4'b0101, 1'b1, 1'b0, 1'b1, 2'b00});
        tbl.push_back('{4'b1010, 1'b0, 1'b1, 1'b1, 2'b01});
        run_tbl("toggle");

        // Asynchronous reset while running, without a clock edge
        #2 RST_N = 1'b0;
        #1;
        chk("async_rst_o", 64'(bus.O), 64'd0);
        chk("async_rst_done", 64'(bus.CFG_DONE), 64'd0);
        chk("async_rst_do", 64'(bus.CFG_DO), 64'd0);
        step();
        #2 RST_N = 1'b1;
        step();
        chk("post_rst_o", 64'(bus.O), 64'd0);

        // Partial load aborted by reset, then a full load is required
        bus.I = 4'b0000;
        for (int n = 0; n < 20; n++) begin
            bus.CFG_EN = 1'b1;
            bus.CFG_DI = c4[n];
            step();
        end
        bus.CFG_EN = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        chk("partial_rst_done", 64'(bus.CFG_DONE), 64'd0);
        RST_N = 1'b1;
        step();
        load_cfg(c4, -1, 1'b0);
        chk("sre_entry", 64'(bus.O), 64'b10);
        tbl.push_back('{4'b0000, 1'b1, 1'b1, 1'b1, 2'b10});
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 1'b1, 2'b11});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 1'b1, 2'b10});
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 1'b1, 2'b11});
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 1'b1, 2'b10});
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 1'b1, 2'b11});
        tbl.push_back('{4'b0000, 1'b1, 1'b1, 1'b1, 2'b10});
        run_tbl("set_reset");

        // Paused reconfiguration; CFG_DO shows old bit 31 after 31 shifts
        abort_run();
        load_cfg(c5, 30, c4[31]);
        chk("c5_entry", 64'(bus.O), 64'b01);
        chk("c5_do", 64'(bus.CFG_DO), 64'(c5[0]));
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 1'b1, 2'b00});
        run_tbl("sre0_set_ignored");

        abort_run();
        load_cfg(c6, -1, 1'b0);
        chk("c6_entry", 64'(bus.O), 64'b00);
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 1'b1, 2'b01});
        tbl.push_back('{4'b0000, 1'b1, 1'b1, 1'b1, 2'b01});
        run_tbl("sre0_reset_ignored");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
